// File: rtl/divu_unit.sv
`default_nettype none
// ============================================================================
// Module   : divu_unit
// Brief    : Sequential restoring divider (quotient -> Lo, remainder -> Hi),
//            start/busy/done handshake, fixed WIDTH+1 cycle latency.
//            Optional signed DIV support when DIVU_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module divu_unit #(
    parameter int          WIDTH      = 32,
    parameter logic [5:0]  DIVU_FUNCT = 6'b011011
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_stateNext;

    logic [WIDTH-1:0]     r_dividend;
    logic [WIDTH-1:0]     r_divisor;
    logic [WIDTH-1:0]     r_rem;
    logic [c_CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]     r_quotient;
    logic [WIDTH-1:0]     r_remainder;
    logic                 r_dbz;

    logic                 w_isDivCode;
    logic                 w_accept;
    logic                 w_lastStep;
    logic [WIDTH-1:0]     w_magA;
    logic [WIDTH-1:0]     w_magB;
    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_trial;
    logic                 w_qBit;
    logic [WIDTH-1:0]     w_remNext;
    logic [WIDTH-1:0]     w_quoNext;
    logic                 w_dbz;
    logic [WIDTH-1:0]     w_resQ;
    logic [WIDTH-1:0]     w_resR;

`ifdef DIVU_SIGNED_EN
    localparam logic [5:0] c_DIV_FUNCT = 6'b011010;

    logic                 r_signedOp;
    logic                 r_negQ;
    logic                 r_negR;
    logic [WIDTH-1:0]     r_origA;
    logic                 w_signedReq;

    assign w_signedReq = (Signal == c_DIV_FUNCT);
    assign w_isDivCode = (Signal == DIVU_FUNCT) || w_signedReq;
    assign w_magA      = (w_signedReq && dataA[WIDTH-1]) ? -dataA : dataA;
    assign w_magB      = (w_signedReq && dataB[WIDTH-1]) ? -dataB : dataB;
`else
    assign w_isDivCode = (Signal == DIVU_FUNCT);
    assign w_magA      = dataA;
    assign w_magB      = dataB;
`endif

    assign w_accept   = (r_state == IDLE) && start && w_isDivCode;
    assign w_lastStep = (r_count == c_CNT_W'(WIDTH - 1));

    // One restoring step: the extra top bit of the trial is the borrow/sign.
    assign w_shifted = {r_rem, r_dividend[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_qBit    = ~w_trial[WIDTH];
    assign w_remNext = w_qBit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
    assign w_quoNext = {r_dividend[WIDTH-2:0], w_qBit};
    assign w_dbz     = (r_divisor == '0);

    always_comb begin
        w_resQ = w_quoNext;
        w_resR = w_remNext;
`ifdef DIVU_SIGNED_EN
        if (r_signedOp && w_dbz) begin
            // Magnitude core would return |A|; report the original signed dividend.
            w_resQ = '1;
            w_resR = r_origA;
        end else begin
            if (r_negQ) w_resQ = -w_quoNext;
            if (r_negR) w_resR = -w_remNext;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: if (w_accept) w_stateNext = RUN;
            RUN: begin
                busy = 1'b1;
                if (w_lastStep) w_stateNext = DONE;
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_rem       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
`ifdef DIVU_SIGNED_EN
            r_signedOp  <= 1'b0;
            r_negQ      <= 1'b0;
            r_negR      <= 1'b0;
            r_origA     <= '0;
`endif
        end else if (w_accept) begin
            r_dividend  <= w_magA;
            r_divisor   <= w_magB;
            r_rem       <= '0;
            r_count     <= '0;
`ifdef DIVU_SIGNED_EN
            r_signedOp  <= w_signedReq;
            r_negQ      <= w_signedReq && (dataA[WIDTH-1] ^ dataB[WIDTH-1]);
            r_negR      <= w_signedReq && dataA[WIDTH-1];
            r_origA     <= dataA;
`endif
        end else if (r_state == RUN) begin
            r_dividend <= w_quoNext;
            r_rem      <= w_remNext;
            r_count    <= r_count + c_CNT_W'(1);
            // Results land on the edge entering DONE so they are valid with done.
            if (w_lastStep) begin
                r_quotient  <= w_resQ;
                r_remainder <= w_resR;
                r_dbz       <= w_dbz;
            end
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_divu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_divu_unit
// Brief    : Directed self-checking bench for divu_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  Signal;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int lat;
    bit held;
    bit seen;

    divu_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .Signal      (Signal),
        .dataA       (dataA),
        .dataB       (dataB),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts cycles from acceptance until done; flags any busy drop or output change.
    task automatic waitDone(output int latency, output bit stable);
        logic [31:0] prevQ;
        prevQ   = quotient;
        latency = 1;
        stable  = 1'b1;
        while (done !== 1'b1 && latency < 40) begin
            if (busy !== 1'b1 || quotient !== prevQ) stable = 1'b0;
            stepClk();
            latency++;
        end
    endtask

    task automatic runDiv(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                          output int latency, output bit stable);
        dataA  = a;
        dataB  = b;
        Signal = sig;
        start  = 1'b1;
        stepClk();
        start  = 1'b0;
        dataA  = $urandom;
        dataB  = $urandom;
        waitDone(latency, stable);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; Signal = 6'd0; dataA = '0; dataB = '0;
        repeat (2) stepClk();
        rst = 1'b0;
        chk("rstBusy", {31'd0, busy}, 32'd0);
        chk("rstDone", {31'd0, done}, 32'd0);
        chk("rstQuo", quotient, 32'd0);
        chk("rstRem", remainder, 32'd0);
        chk("rstDbz", {31'd0, div_by_zero}, 32'd0);

        // 100/7 with ignored restarts at busy cycles 5 and 32
        dataA = 32'd100; dataB = 32'd7; Signal = 6'b011011; start = 1'b1;
        stepClk();
        start = 1'b0; dataA = 32'd8; dataB = 32'd2;
        held = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            if (busy !== 1'b1 || done !== 1'b0 || quotient !== 32'd0) held = 1'b0;
            if (c == 5 || c == 32) start = 1'b1;
            stepClk();
            start = 1'b0;
        end
        chk("basicBusy32", {31'd0, held}, 32'd1);
        chk("basicDone", {31'd0, done}, 32'd1);
        chk("basicBusyLow", {31'd0, busy}, 32'd0);
        chk("basicQuo", quotient, 32'd14);
        chk("basicRem", remainder, 32'd2);
        chk("basicDbz", {31'd0, div_by_zero}, 32'd0);

        // start held through DONE: refused in DONE, accepted in following IDLE
        start = 1'b1;
        stepClk();
        chk("doneStartIgnored", {31'd0, busy}, 32'd0);
        chk("donePulseOnce", {31'd0, done}, 32'd0);
        stepClk();
        start = 1'b0;
        waitDone(lat, held);
        chk("after8by2Lat", lat, 32'd33);
        chk("after8by2Quo", quotient, 32'd4);
        chk("after8by2Rem", remainder, 32'd0);
        stepClk();

        runDiv(32'hFFFF_FFFF, 32'd1, 6'b011011, lat, held);
        chk("maxBy1Lat", lat, 32'd33);
        chk("maxBy1Quo", quotient, 32'hFFFF_FFFF);
        chk("maxBy1Rem", remainder, 32'd0);
        stepClk();

        runDiv(32'd5, 32'd9, 6'b011011, lat, held);
        chk("smallHeld", {31'd0, held}, 32'd1);
        chk("smallQuo", quotient, 32'd0);
        chk("smallRem", remainder, 32'd5);
        stepClk();

        runDiv(32'd1234, 32'd0, 6'b011011, lat, held);
        chk("dbzLat", lat, 32'd33);
        chk("dbzQuo", quotient, 32'hFFFF_FFFF);
        chk("dbzRem", remainder, 32'd1234);
        chk("dbzFlag", {31'd0, div_by_zero}, 32'd1);
        stepClk();

        // reset at busy cycle 10 discards the run and clears held results
        dataA = 32'd100; dataB = 32'd7; Signal = 6'b011011; start = 1'b1;
        stepClk();
        start = 1'b0;
        repeat (9) stepClk();
        chk("midBusyBeforeRst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        stepClk();
        rst = 1'b0;
        chk("midRstBusy", {31'd0, busy}, 32'd0);
        chk("midRstQuo", quotient, 32'd0);
        chk("midRstRem", remainder, 32'd0);
        chk("midRstDbz", {31'd0, div_by_zero}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            if (done === 1'b1) seen = 1'b1;
            stepClk();
        end
        chk("midRstNoDone", {31'd0, seen}, 32'd0);

        dataA = 32'd8; dataB = 32'd2; Signal = 6'b100000; start = 1'b1;
        stepClk();
        start = 1'b0;
        chk("otherFunctIgnored", {31'd0, busy}, 32'd0);
        stepClk();

`ifdef DIVU_SIGNED_EN
        runDiv(32'hFFFF_FFF9, 32'd2, 6'b011010, lat, held);
        chk("sNeg7By2Lat", lat, 32'd33);
        chk("sNeg7By2Quo", quotient, 32'hFFFF_FFFD);
        chk("sNeg7By2Rem", remainder, 32'hFFFF_FFFF);
        stepClk();
        runDiv(32'd7, 32'hFFFF_FFFE, 6'b011010, lat, held);
        chk("s7ByNeg2Quo", quotient, 32'hFFFF_FFFD);
        chk("s7ByNeg2Rem", remainder, 32'd1);
        stepClk();
        runDiv(32'h8000_0000, 32'hFFFF_FFFF, 6'b011010, lat, held);
        chk("sMinByNeg1Quo", quotient, 32'h8000_0000);
        chk("sMinByNeg1Rem", remainder, 32'd0);
        stepClk();
        runDiv(32'hFFFF_FFFB, 32'd0, 6'b011010, lat, held);
        chk("sDbzQuo", quotient, 32'hFFFF_FFFF);
        chk("sDbzRem", remainder, 32'hFFFF_FFFB);
        chk("sDbzFlag", {31'd0, div_by_zero}, 32'd1);
        stepClk();
`else
        dataA = 32'hFFFF_FFF9; dataB = 32'd2; Signal = 6'b011010; start = 1'b1;
        stepClk();
        start = 1'b0;
        chk("signedFunctIgnored", {31'd0, busy}, 32'd0);
        stepClk();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
